// File: rtl/mac_iter_sequencer_pkg.sv
// Shared constants, job/config structs and FSM state encoding for the MAC
// iteration sequencer.
package mac_iter_sequencer_pkg;

  localparam int CNT_LEN = 1024;
  localparam int LW      = $clog2(CNT_LEN) + 1;
  localparam int ITER_W  = 16;

  typedef logic [2:0] state_fsm_t;

  localparam state_fsm_t ST_IDLE      = 3'd0;
  localparam state_fsm_t ST_START     = 3'd1;
  localparam state_fsm_t ST_COMPUTE   = 3'd2;
  localparam state_fsm_t ST_WAIT      = 3'd3;
  localparam state_fsm_t ST_UPDATEIDX = 3'd4;
  localparam state_fsm_t ST_TERMINATE = 3'd5;

  // Part of a job that must stay latched for the whole run.
  typedef struct packed {
    logic [ITER_W-1:0] nb_iter;
    logic [LW-1:0]     len;
    logic [4:0]        shift;
    logic              simple_mul;
    logic [31:0]       iter_stride;
    logic [31:0]       one_stride;
  } ctrl_cfg_t;

  typedef struct packed {
    logic [31:0] a_base;
    logic [31:0] b_base;
    logic [31:0] c_base;
    logic [31:0] d_base;
    ctrl_cfg_t   cfg;
  } ctrl_seq_t;

  // Extra bit keeps iter+1 from wrapping when nb_iter is at its maximum.
  function automatic logic last_iter(input logic [ITER_W-1:0] iter,
                                     input logic [ITER_W-1:0] nb_iter);
    return ({1'b0, iter} + (ITER_W+1)'(1)) == {1'b0, nb_iter};
  endfunction

endpackage

// File: rtl/mac_iter_sequencer_if.sv
// Handshake bundle between the sequencer and the MAC streamer/engine.
interface mac_iter_sequencer_if;
  import mac_iter_sequencer_pkg::*;

  logic              src_ready_i;
  logic              sink_ready_i;
  logic              acc_done_i;
  logic              sink_done_i;
  logic [31:0]       a_addr_o;
  logic [31:0]       b_addr_o;
  logic [31:0]       c_addr_o;
  logic [31:0]       d_addr_o;
  logic              src_req_start_o;
  logic              sink_req_start_o;
  logic              eng_clear_o;
  logic              eng_start_o;
  logic              eng_enable_o;
  logic [LW-1:0]     eng_len_o;
  logic [4:0]        eng_shift_o;
  logic              eng_simple_mul_o;

  modport master (
    input  src_ready_i, sink_ready_i, acc_done_i, sink_done_i,
    output a_addr_o, b_addr_o, c_addr_o, d_addr_o,
           src_req_start_o, sink_req_start_o,
           eng_clear_o, eng_start_o, eng_enable_o,
           eng_len_o, eng_shift_o, eng_simple_mul_o
  );

  modport slave (
    output src_ready_i, sink_ready_i, acc_done_i, sink_done_i,
    input  a_addr_o, b_addr_o, c_addr_o, d_addr_o,
           src_req_start_o, sink_req_start_o,
           eng_clear_o, eng_start_o, eng_enable_o,
           eng_len_o, eng_shift_o, eng_simple_mul_o
  );
endinterface

// File: rtl/mac_iter_sequencer_addr_stepper.sv
// Four per-stream address registers: loaded from the job bases, stepped by
// the iteration stride (C/D use one_stride in accumulate mode).
module mac_addr_stepper (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        simple_mul_i,
  input  logic [31:0] a_base_i,
  input  logic [31:0] b_base_i,
  input  logic [31:0] c_base_i,
  input  logic [31:0] d_base_i,
  input  logic [31:0] iter_stride_i,
  input  logic [31:0] one_stride_i,
  output logic [31:0] a_addr_o,
  output logic [31:0] b_addr_o,
  output logic [31:0] c_addr_o,
  output logic [31:0] d_addr_o
);

  logic [31:0] cd_stride;

  assign cd_stride = simple_mul_i ? iter_stride_i : one_stride_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_addr_o <= '0;
      b_addr_o <= '0;
      c_addr_o <= '0;
      d_addr_o <= '0;
    end else if (clear_i) begin
      a_addr_o <= '0;
      b_addr_o <= '0;
      c_addr_o <= '0;
      d_addr_o <= '0;
    end else if (load_i) begin
      a_addr_o <= a_base_i;
      b_addr_o <= b_base_i;
      c_addr_o <= c_base_i;
      d_addr_o <= d_base_i;
    end else if (step_i) begin
      a_addr_o <= a_addr_o + iter_stride_i;
      b_addr_o <= b_addr_o + iter_stride_i;
      c_addr_o <= c_addr_o + cd_stride;
      d_addr_o <= d_addr_o + cd_stride;
    end
  end

endmodule

// File: rtl/mac_iter_sequencer.sv
// Job sequencer between the register file and the MAC streamer/engine:
// runs nb_iter iterations of stream start, compute, completion wait, address step.
//
// state      | meaning
// IDLE       | no job; waits for start_i
// START      | waits for all streams ready, then fires request/engine-start pulses
// COMPUTE    | engine enabled; waits for accumulation (or sink in simple-mul)
// WAIT       | accumulation done, waiting for the sink to finish
// UPDATEIDX  | advance iteration and addresses, or finish
// TERMINATE  | one-cycle done_o pulse
module mac_iter_sequencer
  import mac_iter_sequencer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [31:0]       a_base_i,
  input  logic [31:0]       b_base_i,
  input  logic [31:0]       c_base_i,
  input  logic [31:0]       d_base_i,
  input  logic [ITER_W-1:0] nb_iter_i,
  input  logic [LW-1:0]     len_i,
  input  logic [4:0]        shift_i,
  input  logic              simple_mul_i,
  input  logic [31:0]       iter_stride_i,
  input  logic [31:0]       one_stride_i,
  mac_iter_sequencer_if.master bus,
  output logic [ITER_W-1:0] iter_o,
  output state_fsm_t        state_o,
  output logic              busy_o,
  output logic              done_o
);

  state_fsm_t        state_q, state_d;
  ctrl_seq_t         job_in;
  ctrl_cfg_t         cfg_q;
  logic [ITER_W-1:0] iter_q;
  logic              sticky_q;
  logic              fire, sink_seen, is_last, load, step;

  always_comb begin
    job_in                 = '0;
    job_in.a_base          = a_base_i;
    job_in.b_base          = b_base_i;
    job_in.c_base          = c_base_i;
    job_in.d_base          = d_base_i;
    job_in.cfg.nb_iter     = nb_iter_i;
    job_in.cfg.len         = len_i;
    job_in.cfg.shift       = shift_i;
    job_in.cfg.simple_mul  = simple_mul_i;
    job_in.cfg.iter_stride = iter_stride_i;
    job_in.cfg.one_stride  = one_stride_i;
  end

  assign fire      = (state_q == ST_START) & bus.src_ready_i & bus.sink_ready_i;
  // A sink completion seen during COMPUTE is remembered until UPDATEIDX.
  assign sink_seen = bus.sink_done_i | sticky_q;
  assign is_last   = last_iter(iter_q, cfg_q.nb_iter);
  assign load      = (state_q == ST_IDLE) & start_i;
  assign step      = (state_q == ST_UPDATEIDX) & ~is_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if ((job_in.cfg.nb_iter == '0) || (job_in.cfg.len == '0))
            state_d = ST_TERMINATE;
          else
            state_d = ST_START;
        end
      end
      ST_START:   if (fire) state_d = ST_COMPUTE;
      ST_COMPUTE: begin
        if (cfg_q.simple_mul) begin
          if (sink_seen) state_d = ST_UPDATEIDX;
        end else if (bus.acc_done_i) begin
          state_d = sink_seen ? ST_UPDATEIDX : ST_WAIT;
        end
      end
      ST_WAIT:      if (sink_seen) state_d = ST_UPDATEIDX;
      ST_UPDATEIDX: state_d = is_last ? ST_TERMINATE : ST_START;
      ST_TERMINATE: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cfg_q    <= '0;
      iter_q   <= '0;
      sticky_q <= 1'b0;
    end else if (clear_i) begin
      state_q  <= ST_IDLE;
      cfg_q    <= '0;
      iter_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cfg_q  <= job_in.cfg;
        iter_q <= '0;
      end else if (step) begin
        iter_q <= iter_q + ITER_W'(1);
      end
      if (load || (state_q == ST_UPDATEIDX))
        sticky_q <= 1'b0;
      else if ((state_q == ST_COMPUTE) && bus.sink_done_i)
        sticky_q <= 1'b1;
    end
  end

  mac_addr_stepper u_addr_stepper (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .load_i        (load),
    .step_i        (step),
    .simple_mul_i  (cfg_q.simple_mul),
    .a_base_i      (job_in.a_base),
    .b_base_i      (job_in.b_base),
    .c_base_i      (job_in.c_base),
    .d_base_i      (job_in.d_base),
    .iter_stride_i (cfg_q.iter_stride),
    .one_stride_i  (cfg_q.one_stride),
    .a_addr_o      (bus.a_addr_o),
    .b_addr_o      (bus.b_addr_o),
    .c_addr_o      (bus.c_addr_o),
    .d_addr_o      (bus.d_addr_o)
  );

  assign bus.src_req_start_o  = fire;
  assign bus.sink_req_start_o = fire;
  assign bus.eng_clear_o      = fire;
  assign bus.eng_start_o      = fire;
  assign bus.eng_enable_o     = (state_q == ST_COMPUTE);
  assign bus.eng_len_o        = cfg_q.len;
  assign bus.eng_shift_o      = cfg_q.shift;
  assign bus.eng_simple_mul_o = cfg_q.simple_mul;

  assign iter_o  = iter_q;
  assign state_o = state_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_TERMINATE);

endmodule
